// File: rtl/conv_window_if.sv
// conv_window_if: pixel-in / window-out handshake bundle for conv_window_gen
//   in_valid/in_ready/in_pixel  : raster pixel stream into the generator
//   out_valid/out_ready/out_win : 3x3 window stream out (slot k=i*3+j at [k*DATA_W +: DATA_W])
//   frame_done                  : 1-cycle pulse after the last pixel of a frame is accepted
//   master modport = upstream/downstream driver side, slave modport = the generator
interface conv_window_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_pixel;
    logic                  out_valid;
    logic                  out_ready;
    logic [9*DATA_W-1:0]   out_win;
    logic                  frame_done;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_win, frame_done
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_win, frame_done
    );
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 sliding-window generator (no padding)
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : conv_window_if.slave carrying the pixel input handshake,
//              the window output handshake and the frame_done pulse
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input logic          clk,
    input logic          rst,
    conv_window_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Line buffers are deliberately not reset: row/col gating keeps stale
    // contents out of every emitted window.
    logic [DATA_W-1:0]   lb0_q [IMG_W];
    logic [DATA_W-1:0]   lb1_q [IMG_W];
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [9*DATA_W-1:0] win_q, win_d;
    logic [9*DATA_W-1:0] out_win_q, out_win_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                acc, emit, col_last, row_last;

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign acc            = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_win    = out_win_q;
    assign bus.frame_done = frame_done_q;

    always_comb begin
        col_last = col_q == COL_LAST;
        row_last = row_q == ROW_LAST;
        emit     = acc && row_q >= ROW_TWO && col_q >= COL_TWO;
        col_d    = acc ? (col_last ? '0 : col_q + 1'b1) : col_q;
        row_d    = (acc && col_last) ? (row_last ? '0 : row_q + 1'b1) : row_q;
        win_d    = win_q;
        if (acc) begin
            // shift every row left one column, then load the new right column
            for (int i = 0; i < 3; i++) begin
                win_d[(3*i)*DATA_W +: DATA_W]   = win_q[(3*i+1)*DATA_W +: DATA_W];
                win_d[(3*i+1)*DATA_W +: DATA_W] = win_q[(3*i+2)*DATA_W +: DATA_W];
            end
            win_d[2*DATA_W +: DATA_W] = lb1_q[col_q];
            win_d[5*DATA_W +: DATA_W] = lb0_q[col_q];
            win_d[8*DATA_W +: DATA_W] = bus.in_pixel;
        end
        // a fresh window wins over a simultaneous consume
        out_valid_d  = emit || (out_valid_q && !bus.out_ready);
        out_win_d    = emit ? win_d : out_win_q;
        frame_done_d = acc && col_last && row_last;
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            out_win_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            out_win_q    <= out_win_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed self-checking bench for conv_window_gen (4x4 and 3x3 frames)
module tb_conv_window_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_if #(.DATA_W(8)) b4 ();
    conv_window_if #(.DATA_W(8)) b3 ();

    conv_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
    conv_window_gen #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

    localparam logic [71:0] FIRST_W = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    localparam logic [71:0] LAST_W  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
    localparam logic [71:0] FIFTH_W = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};
    localparam logic [71:0] W3      = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

    int          n_checks = 0;
    int          n_errors = 0;
    int          fd_cnt;
    int          idx;
    int          cyc;
    int          n3;
    int          fd3;
    logic        acc;
    logic [71:0] w3_got;
    logic [71:0] got[$];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // window n (raster order) of a 4x4 frame whose pixel (0,0) is base
    function automatic logic [71:0] exp_win(input int base, input int n);
        logic [71:0] w;
        int r, c;
        r = 2 + n / 2;
        c = 2 + n % 2;
        for (int k = 0; k < 9; k++)
            w[k*8 +: 8] = 8'(base + (r - 2 + k / 3) * 4 + (c - 2 + k % 3));
        return w;
    endfunction

    // drive one cycle at negedge, sample 1 time unit later (well before posedge)
    task automatic step(input logic v, input logic [7:0] pix, input logic rdy, output logic a);
        @(negedge clk);
        b4.in_valid  = v;
        b4.in_pixel  = pix;
        b4.out_ready = rdy;
        #1;
        a = b4.in_valid && b4.in_ready;
        if (b4.out_valid && b4.out_ready) got.push_back(b4.out_win);
        if (b4.frame_done) begin
            fd_cnt++;
            check("fd_with_valid", 72'(b4.out_valid), 72'd1);
        end
    endtask

    // mode 0: steady, 1: random gaps and backpressure, 2: steady with out_ready=0
    task automatic run_frame(input int base, input int start, input int npix, input int mode);
        int i = start;
        int c = 0;
        logic v, r, a;
        while (i < npix && c < 500) begin
            v = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode != 2);
            step(v, 8'(base + i), r, a);
            if (a) i++;
            c++;
        end
        if (c >= 500) check("stream_timeout", 72'(i), 72'(npix));
    endtask

    task automatic drain();
        logic a;
        repeat (4) step(1'b0, 8'd0, 1'b1, a);
    endtask

    task automatic check_wins(input string tag, input int nwin, input int base_a, input int base_b);
        check({tag, "_count"}, 72'(got.size()), 72'(nwin));
        for (int k = 0; k < nwin && k < got.size(); k++)
            check($sformatf("%s_win%0d", tag, k), got[k], exp_win(k < 4 ? base_a : base_b, k % 4));
    endtask

    initial begin
        b4.in_valid = 1'b0; b4.in_pixel = '0; b4.out_ready = 1'b0;
        b3.in_valid = 1'b0; b3.in_pixel = '0; b3.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 72'(b4.out_valid), 72'd0);
        check("rst_frame_done", 72'(b4.frame_done), 72'd0);
        check("rst_out_win", b4.out_win, 72'd0);
        check("rst_in_ready", 72'(b4.in_ready), 72'd1);
        check("rst3_out_valid", 72'(b3.out_valid), 72'd0);
        rst = 1'b0;

        // 1: single frame, no backpressure
        got.delete(); fd_cnt = 0;
        run_frame(0, 0, 16, 0); drain();
        check_wins("t1", 4, 0, 0);
        if (got.size() == 4) begin
            check("t1_first", got[0], FIRST_W);
            check("t1_last", got[3], LAST_W);
        end
        check("t1_fd_cnt", 72'(fd_cnt), 72'd1);

        // 2: stall the first window, then release
        got.delete(); fd_cnt = 0; idx = 0; cyc = 0;
        while (!b4.out_valid && cyc < 100) begin
            step(1'b1, 8'(idx), 1'b0, acc);
            if (acc) idx++;
            cyc++;
        end
        check("t2_accepted", 72'(idx), 72'd11);
        repeat (3) begin
            step(1'b1, 8'(idx), 1'b0, acc);
            check("t2_in_ready", 72'(b4.in_ready), 72'd0);
            check("t2_hold_win", b4.out_win, FIRST_W);
        end
        run_frame(0, idx, 16, 0); drain();
        check_wins("t2", 4, 0, 0);
        check("t2_fd_cnt", 72'(fd_cnt), 72'd1);

        // 3: random input gaps and output backpressure
        got.delete(); fd_cnt = 0;
        run_frame(0, 0, 16, 1); drain();
        check_wins("t3", 4, 0, 0);
        check("t3_fd_cnt", 72'(fd_cnt), 72'd1);

        // 4: two frames back to back
        got.delete(); fd_cnt = 0;
        run_frame(0, 0, 16, 0); run_frame(100, 0, 16, 0); drain();
        check_wins("t4", 8, 0, 100);
        if (got.size() >= 5) check("t4_fifth", got[4], FIFTH_W);
        check("t4_fd_cnt", 72'(fd_cnt), 72'd2);

        // 5a: reset after pixel 9, then a clean frame
        run_frame(0, 0, 10, 0);
        @(negedge clk); b4.in_valid = 1'b0; rst = 1'b1; #1;
        check("t5_rst_valid", 72'(b4.out_valid), 72'd0);
        @(negedge clk); rst = 1'b0;
        got.delete(); fd_cnt = 0;
        run_frame(0, 0, 16, 0); drain();
        check_wins("t5", 4, 0, 0);

        // 5b: reset while a window is pending clears out_valid immediately
        run_frame(0, 0, 11, 2);
        step(1'b0, 8'd0, 1'b0, acc);
        check("t5_pending", 72'(b4.out_valid), 72'd1);
        @(negedge clk); rst = 1'b1; #1;
        check("t5_async_clr", 72'(b4.out_valid), 72'd0);
        check("t5_fd_clr", 72'(b4.frame_done), 72'd0);
        @(negedge clk); rst = 1'b0;
        got.delete(); fd_cnt = 0;
        run_frame(0, 0, 16, 0); drain();
        check_wins("t5b", 4, 0, 0);
        check("t5b_fd_cnt", 72'(fd_cnt), 72'd1);

        // 6: 3x3 frame gives exactly one window
        idx = 0; n3 = 0; fd3 = 0; w3_got = '0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            b3.in_valid  = idx < 9;
            b3.in_pixel  = 8'(idx + 1);
            b3.out_ready = 1'b1;
            #1;
            if (b3.out_valid) begin
                n3++;
                w3_got = b3.out_win;
                check("t6_fd_same_cycle", 72'(b3.frame_done), 72'd1);
            end
            if (b3.frame_done) fd3++;
            if (b3.in_valid && b3.in_ready) idx++;
        end
        check("t6_count", 72'(n3), 72'd1);
        check("t6_win", w3_got, W3);
        check("t6_fd_cnt", 72'(fd3), 72'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
